// File: rtl/rv32i_decode.sv
// RV32I instruction decoder: raw field slices, format-selected sign-extended
// immediate, combinational illegal-instruction flag and a sticky record of
// any illegal instruction presented with insn_valid.
module rv32i_decode (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] insn,
    input  logic        insn_valid,
    output logic [4:0]  opcode,
    output logic [6:0]  funct7,
    output logic [2:0]  funct3,
    output logic        invalid,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [31:0] imm,
    output logic        invalid_seen
);

    localparam logic [4:0] OpLoad   = 5'b00000;
    localparam logic [4:0] OpMisc   = 5'b00011;
    localparam logic [4:0] OpAluImm = 5'b00100;
    localparam logic [4:0] OpAuipc  = 5'b00101;
    localparam logic [4:0] OpStore  = 5'b01000;
    localparam logic [4:0] OpAlu    = 5'b01100;
    localparam logic [4:0] OpLui    = 5'b01101;
    localparam logic [4:0] OpBranch = 5'b11000;
    localparam logic [4:0] OpJalr   = 5'b11001;
    localparam logic [4:0] OpJal    = 5'b11011;
    localparam logic [4:0] OpSystem = 5'b11100;

    localparam logic [31:0] InsnEcall  = 32'h0000_0073;
    localparam logic [31:0] InsnEbreak = 32'h0010_0073;

    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic        invalid_seen_q;

    assign opcode = insn[6:2];
    assign funct7 = insn[31:25];
    assign funct3 = insn[14:12];
    assign rd     = insn[11:7];
    assign rs1    = insn[19:15];
    assign rs2    = insn[24:20];

    assign imm_i = {{20{insn[31]}}, insn[31:20]};
    assign imm_s = {{20{insn[31]}}, insn[31:25], insn[11:7]};
    assign imm_b = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
    assign imm_u = {insn[31:12], 12'b0};
    assign imm_j = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};

    // Immediate format select and per-opcode legality checks.
    always_comb begin
        imm     = '0;
        invalid = 1'b0;
        case (opcode)
            OpLoad: begin
                imm     = imm_i;
                invalid = funct3 inside {3'b011, 3'b110, 3'b111};
            end
            OpMisc: imm = imm_i;
            OpAluImm: begin
                imm = imm_i;
                if (funct3 == 3'b001) begin
                    invalid = funct7 != 7'b0000000;
                end else if (funct3 == 3'b101) begin
                    invalid = !(funct7 == 7'b0000000 || funct7 == 7'b0100000);
                end
            end
            OpAuipc, OpLui: imm = imm_u;
            OpStore: begin
                imm     = imm_s;
                invalid = funct3 > 3'b010;
            end
            OpAlu: begin
                invalid = !(funct7 == 7'b0000000 ||
                            (funct7 == 7'b0100000 && funct3 inside {3'b000, 3'b101}));
            end
            OpBranch: begin
                imm     = imm_b;
                invalid = funct3 inside {3'b010, 3'b011};
            end
            OpJalr: begin
                imm     = imm_i;
                invalid = funct3 != 3'b000;
            end
            OpJal: imm = imm_j;
            OpSystem: begin
                imm     = imm_i;
                invalid = insn != InsnEcall && insn != InsnEbreak;
            end
            default: invalid = 1'b1;
        endcase
        // Non-32-bit encodings and the all-zero/all-one words are always illegal.
        if (insn[1:0] != 2'b11 || insn == '0 || insn == '1) begin
            invalid = 1'b1;
        end
    end

    // Sticky illegal flag; reset wins over a simultaneous illegal instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            invalid_seen_q <= 1'b0;
        end else if (insn_valid && invalid) begin
            invalid_seen_q <= 1'b1;
        end
    end

    assign invalid_seen = invalid_seen_q;

endmodule

// File: tb/tb_rv32i_decode.sv
// Randomized scoreboard bench for rv32i_decode against a behavioural model.
module tb_rv32i_decode;

    typedef struct packed {
        logic [31:0] insn;
        logic [4:0]  opcode;
        logic [6:0]  funct7;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        inv;
        logic        seen;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] insn;
    logic        insn_valid;
    logic [4:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic        invalid;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        invalid_seen;

    exp_t q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    logic model_seen;
    logic prev_rst;
    logic prev_valid;
    logic prev_inv;

    rv32i_decode dut (
        .clk          (clk),
        .rst          (rst),
        .insn         (insn),
        .insn_valid   (insn_valid),
        .opcode       (opcode),
        .funct7       (funct7),
        .funct3       (funct3),
        .invalid      (invalid),
        .rd           (rd),
        .rs1          (rs1),
        .rs2          (rs2),
        .imm          (imm),
        .invalid_seen (invalid_seen)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] sext(input logic [31:0] v, input int w);
        logic signed [31:0] t;
        t = v << (32 - w);
        return t >>> (32 - w);
    endfunction

    // Reference: fields, immediate value and legality from the ISA rules.
    function automatic exp_t model(input logic [31:0] w);
        exp_t e;
        int   op;
        int   f3;
        int   f7;
        op = int'((w >> 2) & 32'h1F);
        f3 = int'((w >> 12) & 32'h7);
        f7 = int'(w >> 25);
        e.insn   = w;
        e.opcode = 5'(op);
        e.funct7 = 7'(f7);
        e.funct3 = 3'(f3);
        e.rd     = 5'((w >> 7) & 32'h1F);
        e.rs1    = 5'((w >> 15) & 32'h1F);
        e.rs2    = 5'((w >> 20) & 32'h1F);
        e.seen   = 1'b0;
        e.imm    = 32'h0;
        e.inv    = 1'b0;
        case (op)
            0, 3, 4, 25, 28: e.imm = sext(w >> 20, 12);
            8:      e.imm = sext(((w >> 25) << 5) | ((w >> 7) & 32'h1F), 12);
            24:     e.imm = sext((((w >> 31) & 1) << 12) | (((w >> 7) & 1) << 11) |
                                 (((w >> 25) & 32'h3F) << 5) | (((w >> 8) & 32'hF) << 1), 13);
            5, 13:  e.imm = w & 32'hFFFF_F000;
            27:     e.imm = sext((((w >> 31) & 1) << 20) | (((w >> 12) & 32'hFF) << 12) |
                                 (((w >> 20) & 1) << 11) | (((w >> 21) & 32'h3FF) << 1), 21);
            default: e.imm = 32'h0;
        endcase
        case (op)
            0:  e.inv = (f3 == 3 || f3 == 6 || f3 == 7);
            3, 5, 13, 27: e.inv = 1'b0;
            4:  e.inv = (f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 32);
            8:  e.inv = f3 > 2;
            12: e.inv = !(f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5)));
            24: e.inv = (f3 == 2 || f3 == 3);
            25: e.inv = f3 != 0;
            28: e.inv = !(w == 32'h0000_0073 || w == 32'h0010_0073);
            default: e.inv = 1'b1;
        endcase
        if ((w & 3) != 3 || w == 32'h0 || w == 32'hFFFF_FFFF) e.inv = 1'b1;
        return e;
    endfunction

    // Drive one vector after the edge, update the sticky model, queue expectation.
    task automatic apply(input logic [31:0] w, input logic v, input logic r);
        exp_t e;
        @(posedge clk);
        #1;
        if (prev_rst) model_seen = 1'b0;
        else if (prev_valid && prev_inv) model_seen = 1'b1;
        insn       = w;
        insn_valid = v;
        rst        = r;
        e          = model(w);
        e.seen     = model_seen;
        q.push_back(e);
        prev_rst   = r;
        prev_valid = v;
        prev_inv   = e.inv;
        vectors++;
    endtask

    task automatic check(input string name, input logic [31:0] w,
                         input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s insn=%08h got=%08h expected=%08h", name, w, act, exp);
        end
    endtask

    // Monitor: outputs are combinational, so compare mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            check("opcode", e.insn, 32'(opcode), 32'(e.opcode));
            check("funct7", e.insn, 32'(funct7), 32'(e.funct7));
            check("funct3", e.insn, 32'(funct3), 32'(e.funct3));
            check("rd", e.insn, 32'(rd), 32'(e.rd));
            check("rs1", e.insn, 32'(rs1), 32'(e.rs1));
            check("rs2", e.insn, 32'(rs2), 32'(e.rs2));
            check("imm", e.insn, imm, e.imm);
            check("invalid", e.insn, 32'(invalid), 32'(e.inv));
            check("invalid_seen", e.insn, 32'(invalid_seen), 32'(e.seen));
        end
    end

    logic [4:0] legal_ops [11] = '{5'b00000, 5'b00011, 5'b00100, 5'b00101, 5'b01000,
                                   5'b01100, 5'b01101, 5'b11000, 5'b11001, 5'b11011,
                                   5'b11100};

    initial begin
        logic [31:0] w;
        int          guard;
        rst        = 1'b1;
        insn       = 32'h0;
        insn_valid = 1'b0;
        prev_rst   = 1'b1;
        prev_valid = 1'b0;
        prev_inv   = 1'b1;
        model_seen = 1'b0;

        apply(32'h0050_0093, 1'b1, 1'b1);
        apply(32'h0050_0093, 1'b1, 1'b0);
        apply(32'h0000_0000, 1'b0, 1'b0);
        apply(32'h0000_0000, 1'b0, 1'b0);
        apply(32'h0000_0000, 1'b1, 1'b0);
        apply(32'hFFF0_0113, 1'b1, 1'b0);
        apply(32'h0020_A423, 1'b1, 1'b0);
        apply(32'hFE00_0EE3, 1'b1, 1'b0);
        apply(32'h0010_00EF, 1'b1, 1'b0);
        apply(32'h1234_52B7, 1'b1, 1'b0);
        apply(32'h4000_5093, 1'b1, 1'b0);
        apply(32'hFFFF_FFFF, 1'b1, 1'b1);
        apply(32'h0000_B003, 1'b1, 1'b0);
        apply(32'h4000_1033, 1'b0, 1'b0);
        apply(32'h0010_0073, 1'b1, 1'b0);
        apply(32'h0000_0073, 1'b1, 1'b0);

        for (int i = 0; i < 600; i++) begin
            w = $urandom;
            case ($urandom_range(0, 7))
                0: ;
                1: w = ($urandom_range(0, 1) != 0) ? 32'h0000_0073 : 32'h0010_0073;
                default: begin
                    w[6:0] = {legal_ops[$urandom_range(0, 10)], 2'b11};
                    if ($urandom_range(0, 1) != 0)
                        w[31:25] = ($urandom_range(0, 1) != 0) ? 7'b0100000 : 7'b0000000;
                end
            endcase
            apply(w, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
        end

        guard = 0;
        while (q.size() != 0 && guard < 10) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain pending=%0d expected=0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
